// File: rtl/turn_countdown_if.sv
// Control/status bundle between the game controller and turn_countdown.
// master = controller side (drives strobes), slave = countdown block.
interface turn_countdown_if;
    localparam int unsigned SECS_W = 7;
    localparam int unsigned BCD_W  = 4;

    logic              tick_in;
    logic              start;
    logic              pause;
    logic              reload;
    logic [SECS_W-1:0] secs_left;
    logic [BCD_W-1:0]  bcd_tens;
    logic [BCD_W-1:0]  bcd_ones;
    logic              running;
    logic              expired;
    logic              expire_pulse;
    logic              warn;

    modport master (
        output tick_in, start, pause, reload,
        input  secs_left, bcd_tens, bcd_ones, running, expired, expire_pulse, warn
    );

    modport slave (
        input  tick_in, start, pause, reload,
        output secs_left, bcd_tens, bcd_ones, running, expired, expire_pulse, warn
    );
endinterface

// File: rtl/turn_countdown.sv
// Game-turn countdown driven by the 1 s timeUp level; binary + BCD readout.
// Optional last-seconds blinking warn output enabled by TURN_COUNTDOWN_WARN_EN.
module turn_countdown #(
    parameter int unsigned START_SECS = 30,
    parameter int unsigned WARN_SECS  = 5
) (
    input  logic            C_50Mhz,
    input  logic            rst_n,
    turn_countdown_if.slave bus
);
    localparam int unsigned SECS_W = 7;
    localparam logic [SECS_W-1:0] START_VAL = SECS_W'(START_SECS);
    localparam logic [SECS_W-1:0] WARN_TOP  = SECS_W'(WARN_SECS + 1);

    // Parameter legality: START_SECS 1..99, WARN_SECS 1..START_SECS.
    if (START_SECS < 1 || START_SECS > 99 || WARN_SECS < 1 || WARN_SECS > START_SECS) begin : g_bad_params
    end

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t            state;
    logic              tick_q;
    logic [SECS_W-1:0] secs;
    logic              running_q;
    logic              expired_q;
    logic              pulse_q;
    logic              tick_rise;

    assign tick_rise = bus.tick_in & ~tick_q;

    // Turn FSM; strobe priority reload > pause > start > tick_rise.
    always_ff @(posedge C_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_q    <= 1'b0;
            secs      <= START_VAL;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            tick_q  <= bus.tick_in;
            pulse_q <= 1'b0;
            case (state)
                IDLE: begin
                    secs <= START_VAL;
                    if (!bus.reload && !bus.pause && bus.start) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.reload) begin
                        secs <= START_VAL;
                    end else if (bus.pause) begin
                        state     <= PAUSED;
                        running_q <= 1'b0;
                    end else if (tick_rise) begin
                        if (secs > SECS_W'(1)) begin
                            secs <= secs - SECS_W'(1);
                        end else begin
                            secs      <= '0;
                            state     <= EXPIRED;
                            running_q <= 1'b0;
                            expired_q <= 1'b1;
                            pulse_q   <= 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (bus.reload) begin
                        state <= IDLE;
                        secs  <= START_VAL;
                    end else if (!bus.pause && bus.start) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                EXPIRED: begin
                    if (bus.reload) begin
                        state     <= IDLE;
                        secs      <= START_VAL;
                        expired_q <= 1'b0;
                    end else if (!bus.pause && bus.start) begin
                        state     <= RUN;
                        secs      <= START_VAL;
                        running_q <= 1'b1;
                        expired_q <= 1'b0;
                    end else begin
                        secs <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    secs      <= START_VAL;
                    running_q <= 1'b0;
                    expired_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.secs_left    = secs;
    assign bus.running      = running_q;
    assign bus.expired      = expired_q;
    assign bus.expire_pulse = pulse_q;
    // Display digits decode straight from the count register.
    assign bus.bcd_tens     = 4'(secs / SECS_W'(10));
    assign bus.bcd_ones     = 4'(secs % SECS_W'(10));

`ifdef TURN_COUNTDOWN_WARN_EN
    logic warn_q;

    // Blink on each tick while the new count lies in 1..WARN_SECS.
    always_ff @(posedge C_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            warn_q <= 1'b0;
        end else if (state != RUN || bus.reload || bus.pause) begin
            warn_q <= 1'b0;
        end else if (tick_rise) begin
            if (secs > SECS_W'(1) && secs <= WARN_TOP) begin
                warn_q <= ~warn_q;
            end else if (secs <= SECS_W'(1)) begin
                warn_q <= 1'b0;
            end
        end
    end

    assign bus.warn = warn_q;
`else
    logic unused_warn;
    assign unused_warn = ^WARN_TOP;
    assign bus.warn    = 1'b0;
`endif
endmodule

// File: tb/tb_turn_countdown.sv
// Self-checking bench for turn_countdown: directed scenarios plus randomized
// strobes compared each cycle against a behavioural turn-budget model.
module tb_turn_countdown;
    localparam int START = 30;
    localparam int WARNS = 5;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   pulses;

    // reference model
    int   m_mode;
    int   m_secs;
    bit   m_tick;
    bit   m_pulse;
    bit   m_warn;

    turn_countdown_if bus ();

    turn_countdown #(.START_SECS(START), .WARN_SECS(WARNS)) dut (
        .C_50Mhz (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic bit exp_warn();
`ifdef TURN_COUNTDOWN_WARN_EN
        return m_warn;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit warn_at(input int secs);
`ifdef TURN_COUNTDOWN_WARN_EN
        return (secs >= 1 && secs <= WARNS) ? (((WARNS - secs) % 2) == 0) : 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_secs = START; m_tick = 1'b0; m_pulse = 1'b0; m_warn = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model across the edge, settle #1 after it.
    task automatic step(input bit t, input bit s, input bit p, input bit r);
        bit rise;
        bus.tick_in = t; bus.start = s; bus.pause = p; bus.reload = r;
        @(posedge clk);
        rise    = t && !m_tick;
        m_tick  = t;
        m_pulse = 1'b0;
        if (m_mode == M_IDLE) begin
            m_secs = START;
            if (!r && !p && s) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (r) begin
                m_secs = START; m_warn = 1'b0;
            end else if (p) begin
                m_mode = M_PAUSED; m_warn = 1'b0;
            end else if (rise) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_mode = M_EXP; m_pulse = 1'b1; m_warn = 1'b0;
                end else if (m_secs <= WARNS) begin
                    m_warn = !m_warn;
                end
            end
        end else begin
            if (r) begin
                m_mode = M_IDLE; m_secs = START;
            end else if (!p && s) begin
                if (m_mode == M_EXP) m_secs = START;
                m_mode = M_RUN;
            end
        end
        #1;
        if (bus.expire_pulse) pulses++;
    endtask

    task automatic tick_pulse(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < lo; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.tick_in = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.reload = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.secs_left !== 7'd30) begin bad++; $display("FAIL reset_secs got=%0d want=30", bus.secs_left); end
        total++; if (bus.bcd_tens !== 4'd3 || bus.bcd_ones !== 4'd0) begin bad++; $display("FAIL reset_bcd got=%0d/%0d want=3/0", bus.bcd_tens, bus.bcd_ones); end
        total++; if (bus.running !== 1'b0 || bus.expired !== 1'b0) begin bad++; $display("FAIL reset_flags got run=%b exp=%b want 0/0", bus.running, bus.expired); end
        total++; if (bus.expire_pulse !== 1'b0 || bus.warn !== 1'b0) begin bad++; $display("FAIL reset_pulse_warn got=%b/%b want 0/0", bus.expire_pulse, bus.warn); end
        // ticks in IDLE are ignored
        tick_pulse(3, 3);
        total++; if (bus.secs_left !== 7'd30) begin bad++; $display("FAIL idle_tick got=%0d want=30", bus.secs_left); end
    endtask

    task automatic test_full_countdown();
        int want;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL start_running got=%b want=1", bus.running); end
        pulses = 0;
        for (int i = 0; i < START; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            want = START - 1 - i;
            total++; if (int'(bus.secs_left) != want) begin bad++; $display("FAIL count_step got=%0d want=%0d", bus.secs_left, want); end
            total++; if (bus.bcd_tens !== 4'(want / 10) || bus.bcd_ones !== 4'(want % 10)) begin bad++; $display("FAIL count_bcd got=%0d/%0d want=%0d", bus.bcd_tens, bus.bcd_ones, want); end
            total++; if (bus.warn !== warn_at(want)) begin bad++; $display("FAIL warn_seq secs=%0d got=%b want=%b", want, bus.warn, warn_at(want)); end
            total++; if (bus.expire_pulse !== (want == 0)) begin bad++; $display("FAIL pulse_edge secs=%0d got=%b want=%b", want, bus.expire_pulse, want == 0); end
            tick_pulse(999, 10);
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL pulse_count got=%0d want=1", pulses); end
        total++; if (bus.expired !== 1'b1 || bus.running !== 1'b0 || bus.secs_left !== 7'd0) begin bad++; $display("FAIL expired_state got exp=%b run=%b secs=%0d want 1/0/0", bus.expired, bus.running, bus.secs_left); end
        tick_pulse(5, 5);
        total++; if (bus.secs_left !== 7'd0 || bus.warn !== 1'b0) begin bad++; $display("FAIL no_wrap got secs=%0d warn=%b want 0/0", bus.secs_left, bus.warn); end
    endtask

    task automatic test_long_high();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.running !== 1'b1 || bus.secs_left !== 7'd30 || bus.expired !== 1'b0) begin bad++; $display("FAIL restart got run=%b secs=%0d exp=%b want 1/30/0", bus.running, bus.secs_left, bus.expired); end
        tick_pulse(5000, 2);
        total++; if (bus.secs_left !== 7'd29) begin bad++; $display("FAIL long_high got=%0d want=29", bus.secs_left); end
    endtask

    task automatic test_pause_tick();
        while (m_secs > 17) tick_pulse(3, 3);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        total++; if (bus.running !== 1'b0 || bus.secs_left !== 7'd17) begin bad++; $display("FAIL pause_drop got run=%b secs=%0d want 0/17", bus.running, bus.secs_left); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick_pulse(4, 4);
        total++; if (bus.secs_left !== 7'd17) begin bad++; $display("FAIL paused_frozen got=%0d want=17", bus.secs_left); end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        tick_pulse(2, 2);
        total++; if (bus.secs_left !== 7'd16 || bus.running !== 1'b1) begin bad++; $display("FAIL resume got secs=%0d run=%b want 16/1", bus.secs_left, bus.running); end
    endtask

    task automatic test_expired_reload();
        while (m_secs > 0) tick_pulse(2, 2);
        total++; if (bus.expired !== 1'b1) begin bad++; $display("FAIL reach_expired got=%b want=1", bus.expired); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (bus.expired !== 1'b0 || bus.running !== 1'b0 || bus.secs_left !== 7'd30) begin bad++; $display("FAIL exp_reload got exp=%b run=%b secs=%0d want 0/0/30", bus.expired, bus.running, bus.secs_left); end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        while (m_secs > 12) tick_pulse(2, 2);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        total++; if (bus.secs_left !== 7'd30 || bus.running !== 1'b1) begin bad++; $display("FAIL reload_over_pause got secs=%0d run=%b want 30/1", bus.secs_left, bus.running); end
    endtask

    task automatic test_async_reset();
        while (m_secs > 8) tick_pulse(2, 2);
        total++; if (bus.secs_left !== 7'd8) begin bad++; $display("FAIL pre_reset got=%0d want=8", bus.secs_left); end
        #4 rst_n = 1'b0;
        #1;
        model_reset();
        total++; if (bus.secs_left !== 7'd30 || bus.running !== 1'b0 || bus.expired !== 1'b0 || bus.bcd_tens !== 4'd3) begin bad++; $display("FAIL async_reset got secs=%0d run=%b exp=%b tens=%0d", bus.secs_left, bus.running, bus.expired, bus.bcd_tens); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick_pulse(3, 3);
        total++; if (bus.secs_left !== 7'd30 || bus.running !== 1'b0) begin bad++; $display("FAIL post_reset_idle got secs=%0d run=%b want 30/0", bus.secs_left, bus.running); end
    endtask

    task automatic test_random();
        bit t, s, p, r, prev_pulse;
        t = 1'b0; prev_pulse = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) t = !t;
            s = ($urandom_range(0, 40) == 0);
            p = ($urandom_range(0, 90) == 0);
            r = ($urandom_range(0, 250) == 0);
            step(t, s, p, r);
            total++;
            if (int'(bus.secs_left) != m_secs || bus.running !== (m_mode == M_RUN) || bus.expired !== (m_mode == M_EXP)
                || bus.expire_pulse !== m_pulse || bus.warn !== exp_warn()
                || bus.bcd_tens !== 4'(m_secs / 10) || bus.bcd_ones !== 4'(m_secs % 10)) begin
                bad++;
                $display("FAIL random c=%0d got secs=%0d run=%b exp=%b pul=%b warn=%b bcd=%0d%0d want secs=%0d mode=%0d pul=%b warn=%b",
                         c, bus.secs_left, bus.running, bus.expired, bus.expire_pulse, bus.warn, bus.bcd_tens, bus.bcd_ones,
                         m_secs, m_mode, m_pulse, exp_warn());
            end
            total++; if (prev_pulse && bus.expire_pulse) begin bad++; $display("FAIL pulse_twice c=%0d got=1 want=0", c); end
            prev_pulse = bus.expire_pulse;
        end
    endtask

    initial begin
        total = 0; bad = 0; pulses = 0;
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_full_countdown();
        test_long_high();
        test_pause_tick();
        test_expired_reload();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
